if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch/decode boundary register that replaces the single-entry IF/ID latch with a DEPTH-entry instruction queue and a registered decode-side output. Fetch keeps producing while decode is stalled until the queue fills, and backpressure is a ready/valid pair instead of a stall bit. Sits between the PC/instruction-ROM fetch stage and the ID stage. It uses the CTRL stall vector for the decode side and a flush input from branch/exception logic.

## Interface
- ADDR_W, 32, width of instruction address (`InstAddrBus`)
- INST_W, 32, width of instruction word (`InstBus`)
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  ADDR_W  address of fetched instruction
- if_inst  in  INST_W  fetched instruction
- if_valid  in  1  if_pc/if_inst carry a real instruction this cycle
- if_ready  out  1  queue can accept; push = if_valid & if_ready
- stall  in  6  CTRL stall vector; only stall[2] (decode stop, 1 = Stop) used
- flush  in  1  discard all queued and output instructions
- id_pc  out  ADDR_W  address of instruction in decode
- id_inst  out  INST_W  instruction in decode
- id_valid  out  1  id_pc/id_inst is a real instruction
- count  out  $clog2(DEPTH+1)  number of queued entries (excludes output register)

## Operation
- Storage: DEPTH-entry circular buffer of {pc, inst}, with read pointer, write pointer, and count registers. Pointers are log2(DEPTH) bits and wrap naturally.
- if_ready = (count != DEPTH). It depends only on registered count, not on a same-cycle pop. When the queue is full, no push is accepted even if a pop occurs.
- Advance condition: adv = (stall[2] == 0).
- Output register update, priority high→low:
  - flush: id_pc = 0, id_inst = 0, id_valid = 0.
  - !adv: hold all id_* outputs.
  - adv & count > 0: load head entry, id_valid = 1, pop.
  - adv & count == 0 & push: bypass case (see Configuration).
  - adv & count == 0 & no push: id_pc = 0, id_inst = 0, id_valid = 0. This is a bubble; a zero word decodes as NOP.
- Queue update:
  - flush: count = 0 and rptr = wptr = 0. A same-cycle push is dropped.
  - Otherwise, push writes at wptr and increments it; pop increments rptr.
  - count += push − pop. A simultaneous push and pop leaves count unchanged.
- A bypassed instruction is not written into the queue.
- FIFO order is strictly preserved: the bypass only fires when the queue is empty.
- Invariant: count ≤ DEPTH. Pushing when full is impossible by construction.

## Timing
- Reset (async, immediate): id_pc = 0, id_inst = 0, id_valid = 0, count = 0, pointers = 0, if_ready = 1.
- Release from reset is synchronous to clk. The first push is accepted on the first edge after rst falls.
- Latency with bypass, empty queue, no stall: instruction pushed at edge N appears on id_* after edge N (one cycle, same as the legacy latch).
- Latency through queue: an instruction is visible on id_* one edge after it reaches the head with adv = 1.
- Throughput: one instruction per cycle in steady state with stall[2] = 0.
- flush takes effect at the next edge. Outputs show a bubble and if_ready = 1 in the following cycle.
- Mid-operation reset clears everything asynchronously. In-flight entries are lost.

## Configuration
- IF_ID_QUEUE_BYPASS_EN:
  - Defined: with an empty queue and adv, the incoming push loads the output register directly. Minimum latency is 1 cycle.
  - Undefined: every instruction is written to the queue first. Minimum latency is 2 cycles, and an empty queue with adv always yields a bubble that cycle.
  - All other behaviour is identical in both builds.

## Test plan
- Reset mid-stream: assert rst with count = 3 → id_valid = 0, id_inst = 0, count = 0, if_ready = 1 immediately, without waiting for a clock edge.
- Streaming, bypass build: push pc 0x0, 0x4, 0x8 on consecutive cycles with stall = 0 → id_pc = 0x0, 0x4, 0x8 on the following three cycles and count stays 0. In the no-bypass build the same sequence appears one cycle later, with count = 1 in steady state.
- Fill under stall: hold stall[2] = 1 and push 5 instructions with DEPTH = 4 → count reaches 4, if_ready = 0, 5th is refused. Release stall → 4 entries emerge in order, one per cycle.
- Wrap-around: push/pop 10 instructions with stall toggling every 3 cycles → output sequence exactly equals input sequence, and pointers wrap with no loss or duplication.
- Flush with simultaneous push: count = 2, flush = 1 and if_valid = 1 in the same cycle → next cycle count = 0, id_valid = 0, and the pushed instruction never reaches id_*.
- Flush while stalled: stall[2] = 1 and flush = 1 → output clears to a bubble despite the stall, because flush has priority over hold.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch/decode boundary bus for if_id_queue.
// master: fetch/control side driving instructions, stall and flush.
// slave : the queue itself.
interface if_id_queue_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] if_pc;
   logic [INST_W-1:0] if_inst;
   logic              if_valid;
   logic              if_ready;
   logic [5:0]        stall;
   logic              flush;
   logic [ADDR_W-1:0] id_pc;
   logic [INST_W-1:0] id_inst;
   logic              id_valid;
   logic [CNT_W-1:0]  count;

   modport master (
      output if_pc, if_inst, if_valid, stall, flush,
      input  if_ready, id_pc, id_inst, id_valid, count
   );

   modport slave (
      input  if_pc, if_inst, if_valid, stall, flush,
      output if_ready, id_pc, id_inst, id_valid, count
   );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID boundary: DEPTH-entry instruction queue feeding a registered decode
// output, with ready/valid backpressure towards fetch and a flush input.
// Optional macro IF_ID_QUEUE_BYPASS_EN: when defined, an instruction arriving
// at an empty queue with decode advancing goes straight to the output register.
module if_id_queue #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst,
   if_id_queue_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];

   logic [PTR_W-1:0]  rptr_q;
   logic [PTR_W-1:0]  wptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_nxt;
   logic              ready_q;

   logic [ADDR_W-1:0] id_pc_q;
   logic [INST_W-1:0] id_inst_q;
   logic              id_valid_q;

   logic adv;
   logic push;
   logic pop;
   logic bypass;
   logic wr;
   logic empty;

   // Only the decode-stop bit of the stall vector matters here.
   logic unused_stall;
   assign unused_stall = ^{bus.stall[5:3], bus.stall[1:0]};

   // Handshake decode and next queue occupancy.
   always_comb begin
      adv       = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      bypass    = 1'b0;
      wr        = 1'b0;
      empty     = 1'b0;
      count_nxt = count_q;

      adv   = !bus.stall[2];
      push  = bus.if_valid & ready_q;
      empty = (count_q == '0);
      pop   = !bus.flush & adv & !empty;
`ifdef IF_ID_QUEUE_BYPASS_EN
      bypass = !bus.flush & adv & empty & push;
`else
      bypass = 1'b0;
`endif
      wr = push & !bus.flush & !bypass;

      if (bus.flush) begin
         count_nxt = '0;
      end else begin
         count_nxt = count_q + CNT_W'(wr) - CNT_W'(pop);
      end
   end

   // Queue pointers, occupancy and registered ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
      end else if (bus.flush) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
      end else begin
         if (wr)  wptr_q <= wptr_q + PTR_W'(1);
         if (pop) rptr_q <= rptr_q + PTR_W'(1);
         count_q <= count_nxt;
         ready_q <= (count_nxt != CNT_W'(DEPTH));
      end
   end

   // Entry storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_pc[wptr_q]   <= bus.if_pc;
         mem_inst[wptr_q] <= bus.if_inst;
      end
   end

   // Decode output register: flush > hold > head > bypass > bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         id_valid_q <= 1'b0;
      end else if (bus.flush) begin
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         id_valid_q <= 1'b0;
      end else if (adv) begin
         if (!empty) begin
            id_pc_q    <= mem_pc[rptr_q];
            id_inst_q  <= mem_inst[rptr_q];
            id_valid_q <= 1'b1;
         end else if (bypass) begin
            id_pc_q    <= bus.if_pc;
            id_inst_q  <= bus.if_inst;
            id_valid_q <= 1'b1;
         end else begin
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
         end
      end
   end

   assign bus.if_ready = ready_q;
   assign bus.count    = count_q;
   assign bus.id_pc    = id_pc_q;
   assign bus.id_inst  = id_inst_q;
   assign bus.id_valid = id_valid_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: accepted pushes are queued as expected
// decode outputs, a monitor pops and compares each newly loaded instruction.
module tb_if_id_queue;
   localparam int unsigned DEPTH = 4;
`ifdef IF_ID_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } item_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_id_queue_if #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) bus ();

   if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    checks = 0;
   int    errors = 0;
   int    m_cnt  = 0;
   item_t exp_q[$];
   bit    acc;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic settle();
      #2;
   endtask

   // One clock cycle of stimulus, with expected-queue and occupancy model update.
   task automatic cyc(input bit v, input logic [31:0] pc, input bit s, input bit f, output bit a);
      bit pop;
      bit byp;
      @(negedge clk);
      chk("count", 64'(bus.count), 64'(m_cnt));
      chk("if_ready", 64'(bus.if_ready), 64'(m_cnt != DEPTH));
      bus.if_valid = v;
      bus.if_pc    = pc;
      bus.if_inst  = inst_of(pc);
      bus.stall    = s ? 6'b000100 : 6'b000000;
      bus.flush    = f;
      a   = v && (m_cnt != DEPTH);
      pop = !f && !s && (m_cnt > 0);
      byp = BYP && !f && !s && (m_cnt == 0) && a;
      if (f) exp_q.delete();
      else if (a) exp_q.push_back({pc, inst_of(pc)});
      @(posedge clk);
      if (f) m_cnt = 0;
      else m_cnt = m_cnt + ((a && !byp) ? 1 : 0) - (pop ? 1 : 0);
   endtask

   // Monitor: every newly loaded decode instruction must match the next expected one.
   initial begin
      bit    f;
      bit    s;
      bit    r;
      item_t e;
      forever begin
         @(posedge clk);
         f = bus.flush;
         s = bus.stall[2];
         r = rst;
         #1;
         if (!r && !rst && !f && !s && bus.id_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_id: got pc %0h, expected nothing", bus.id_pc);
            end else begin
               e = exp_q.pop_front();
               chk("id_pc", 64'(bus.id_pc), 64'(e.pc));
               chk("id_inst", 64'(bus.id_inst), 64'(e.inst));
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      bus.if_valid = 1'b0;
      bus.if_pc    = '0;
      bus.if_inst  = '0;
      bus.stall    = '0;
      bus.flush    = 1'b0;
      #1;
      chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
      chk("rst_id_pc", 64'(bus.id_pc), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_if_ready", 64'(bus.if_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Streaming 0x0, 0x4, 0x8 with no stall.
      cyc(1'b1, 32'h0, 1'b0, 1'b0, acc);
      settle();
      chk("stream_first_valid", 64'(bus.id_valid), 64'(BYP));
      chk("stream_first_count", 64'(bus.count), BYP ? 64'd0 : 64'd1);
      cyc(1'b1, 32'h4, 1'b0, 1'b0, acc);
      cyc(1'b1, 32'h8, 1'b0, 1'b0, acc);
      settle();
      chk("stream_steady_count", 64'(bus.count), BYP ? 64'd0 : 64'd1);
      chk("stream_steady_pc", 64'(bus.id_pc), BYP ? 64'h8 : 64'h4);
      repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      settle();
      chk("stream_bubble_valid", 64'(bus.id_valid), 64'd0);
      chk("stream_bubble_inst", 64'(bus.id_inst), 64'd0);

      // Fill under stall: fifth push refused.
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, acc);
      settle();
      chk("fill_count", 64'(bus.count), 64'd4);
      chk("fill_ready", 64'(bus.if_ready), 64'd0);
      chk("fill_id_valid", 64'(bus.id_valid), 64'd0);
      repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      settle();
      chk("fill_drained", 64'(bus.count), 64'd0);

      // Wrap-around with stall toggling every 3 cycles.
      begin
         int n;
         n = 0;
         for (int t = 0; t < 40; t++) begin
            if (n < 10) begin
               cyc(1'b1, 32'h200 + 32'(4 * n), ((t / 3) % 2) == 1, 1'b0, acc);
               if (acc) n++;
            end else begin
               cyc(1'b0, 32'h0, ((t / 3) % 2) == 1, 1'b0, acc);
            end
         end
      end
      repeat (8) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      settle();
      chk("wrap_all_seen", 64'(exp_q.size()), 64'd0);

      // Flush with a simultaneous push.
      cyc(1'b1, 32'h300, 1'b1, 1'b0, acc);
      cyc(1'b1, 32'h304, 1'b1, 1'b0, acc);
      settle();
      chk("flush_pre_count", 64'(bus.count), 64'd2);
      cyc(1'b1, 32'h308, 1'b0, 1'b1, acc);
      settle();
      chk("flush_count", 64'(bus.count), 64'd0);
      chk("flush_id_valid", 64'(bus.id_valid), 64'd0);
      chk("flush_ready", 64'(bus.if_ready), 64'd1);
      repeat (4) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      settle();
      chk("flush_no_leak", 64'(bus.id_valid), 64'd0);

      // Flush while stalled overrides hold.
      cyc(1'b1, 32'h400, 1'b0, 1'b0, acc);
      if (!BYP) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, acc);
      settle();
      chk("hold_valid", 64'(bus.id_valid), 64'd1);
      chk("hold_pc", 64'(bus.id_pc), 64'h400);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, acc);
      settle();
      chk("stall_flush_valid", 64'(bus.id_valid), 64'd0);
      chk("stall_flush_pc", 64'(bus.id_pc), 64'd0);
      chk("stall_flush_inst", 64'(bus.id_inst), 64'd0);

      // Asynchronous reset mid-stream with three queued entries.
      cyc(1'b1, 32'h4F0, 1'b0, 1'b0, acc);
      if (!BYP) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, acc);
      settle();
      chk("pre_rst_count", 64'(bus.count), 64'd3);
      chk("pre_rst_inst", 64'(bus.id_inst), 64'(inst_of(32'h4F0)));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_id_valid", 64'(bus.id_valid), 64'd0);
      chk("arst_id_inst", 64'(bus.id_inst), 64'd0);
      chk("arst_count", 64'(bus.count), 64'd0);
      chk("arst_if_ready", 64'(bus.if_ready), 64'd1);
      exp_q.delete();
      m_cnt        = 0;
      bus.if_valid = 1'b0;
      bus.stall    = '0;
      @(negedge clk);
      rst = 1'b0;

      // Traffic resumes cleanly after reset.
      cyc(1'b1, 32'h600, 1'b0, 1'b0, acc);
      repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      settle();
      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("final_count", 64'(bus.count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
